// File: rtl/apple1_bus_pkg.sv
// Shared types and default memory map for the Apple-1 style CPU bus responder.
package apple1_bus_pkg;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_IO,
    REG_EXT,
    REG_ROM
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE,
    ST_EXT_WAIT
  } state_t;

  // One latched CPU bus cycle, held stable for the whole access.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    region_t     region;
  } bus_cycle_t;

  localparam logic [15:0] DEF_RAM_TOP     = 16'h1FFF;
  localparam logic [15:0] DEF_IO_BASE     = 16'hD010;
  localparam logic [15:0] DEF_EXT_BASE    = 16'hE000;
  localparam logic [15:0] DEF_EXT_TOP     = 16'hEFFF;
  localparam logic [15:0] DEF_ROM_BASE    = 16'hFF00;
  localparam int          DEF_TIMEOUT_CYC = 64;
  localparam logic [7:0]  DEF_OPEN_BUS    = 8'hFF;

endpackage

// File: rtl/apple1_addr_decode.sv
// Combinational CPU address to region decode; priority RAM > IO > EXT > ROM > NONE.
module apple1_addr_decode
  import apple1_bus_pkg::*;
#(
  parameter logic [15:0] RAM_TOP  = DEF_RAM_TOP,
  parameter logic [15:0] IO_BASE  = DEF_IO_BASE,
  parameter logic [15:0] EXT_BASE = DEF_EXT_BASE,
  parameter logic [15:0] EXT_TOP  = DEF_EXT_TOP,
  parameter logic [15:0] ROM_BASE = DEF_ROM_BASE
) (
  input  logic [15:0] ab,
  output region_t     region
);

  always_comb begin
    region = REG_NONE;
    if (ab <= RAM_TOP) begin
      region = REG_RAM;
    end else if (ab[15:2] == IO_BASE[15:2]) begin
      // Four-register window: the low two address bits select the register.
      region = REG_IO;
    end else if ((ab >= EXT_BASE) && (ab <= EXT_TOP)) begin
      region = REG_EXT;
    end else if (ab >= ROM_BASE) begin
      region = REG_ROM;
    end
  end

endmodule

// File: rtl/apple1_bus_responder.sv
// Target-side responder for the CPU bus: RAM/ROM/IO accesses in fixed time,
// external accesses via req/ack with a timeout that stalls the CPU through ready.
module apple1_bus_responder
  import apple1_bus_pkg::*;
#(
  parameter logic [15:0] RAM_TOP     = DEF_RAM_TOP,
  parameter logic [15:0] IO_BASE     = DEF_IO_BASE,
  parameter logic [15:0] EXT_BASE    = DEF_EXT_BASE,
  parameter logic [15:0] EXT_TOP     = DEF_EXT_TOP,
  parameter logic [15:0] ROM_BASE    = DEF_ROM_BASE,
  parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [7:0]  OPEN_BUS    = DEF_OPEN_BUS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] ab,
  input  logic [7:0]  dbo,
  input  logic        we,
  output logic [7:0]  dbi,
  output logic        ready,
  output logic        bus_err,
  input  logic        bus_err_clr,
  output logic [15:0] ram_addr,
  output logic        ram_en,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  rom_addr,
  output logic        rom_en,
  input  logic [7:0]  rom_rdata,
  output logic        io_sel,
  output logic        io_we,
  output logic [1:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state;
  state_t           state_nxt;
  region_t          region_dec;
  bus_cycle_t       cyc_q;
  logic             start_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             start_ok;
  logic             ext_done;
  logic             ext_timeout;

  apple1_addr_decode #(
    .RAM_TOP  (RAM_TOP),
    .IO_BASE  (IO_BASE),
    .EXT_BASE (EXT_BASE),
    .EXT_TOP  (EXT_TOP),
    .ROM_BASE (ROM_BASE)
  ) u_decode (
    .ab     (ab),
    .region (region_dec)
  );

  // The wrapper presents new ab/we/dbo on the enable clock, so sample one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
    end else begin
      start_q <= enable;
    end
  end

  assign start_ok    = (state == ST_IDLE) && start_q;
  assign ext_done    = (state == ST_EXT_WAIT) && ext_ack;
  // A coincident ack takes priority over expiry.
  assign ext_timeout = (state == ST_EXT_WAIT) && !ext_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_q) begin
          state_nxt = (region_dec == REG_EXT) ? ST_EXT_WAIT : ST_ACCESS;
        end
      end
      ST_ACCESS:  state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      ST_EXT_WAIT: begin
        if (ext_done || ext_timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    rom_en  = 1'b0;
    io_sel  = 1'b0;
    io_we   = 1'b0;
    ext_req = 1'b0;
    ready   = 1'b1;
    case (state)
      ST_ACCESS: begin
        case (cyc_q.region)
          REG_RAM: begin
            ram_en = 1'b1;
            ram_we = cyc_q.we;
          end
          REG_IO: begin
            io_sel = 1'b1;
            io_we  = cyc_q.we;
          end
          REG_ROM: rom_en = !cyc_q.we;
          default: ;
        endcase
      end
      ST_EXT_WAIT: begin
        ext_req = 1'b1;
        ready   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '{addr: 16'h0000, wdata: 8'h00, we: 1'b0, region: REG_NONE};
    end else if (start_ok) begin
      cyc_q <= '{addr: ab, wdata: dbo, we: we, region: region_dec};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ST_EXT_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbi <= OPEN_BUS;
    end else if ((state == ST_CAPTURE) && !cyc_q.we) begin
      case (cyc_q.region)
        REG_RAM: dbi <= ram_rdata;
        REG_IO:  dbi <= io_rdata;
        REG_ROM: dbi <= rom_rdata;
        default: dbi <= OPEN_BUS;
      endcase
    end else if (ext_timeout) begin
      dbi <= OPEN_BUS;
    end else if (ext_done && !cyc_q.we) begin
      dbi <= ext_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if (ext_timeout) begin
      bus_err <= 1'b1;
    end else if (bus_err_clr) begin
      bus_err <= 1'b0;
    end
  end

  assign ram_addr  = cyc_q.addr;
  assign ram_wdata = cyc_q.wdata;
  assign rom_addr  = cyc_q.addr[7:0];
  assign io_addr   = cyc_q.addr[1:0];
  assign io_wdata  = cyc_q.wdata;
  assign ext_addr  = cyc_q.addr;
  assign ext_we    = ext_req && cyc_q.we;
  assign ext_wdata = cyc_q.wdata;

endmodule
